adpcm_main_mul_pipe: RTL

Parametrised, pipelined multiplier for the ADPCM datapath. It is the sequential successor to the combinational fixed-width multiplier cores. It takes two operands with per-operand signedness and computes the full product. It then optionally applies a round-half-up arithmetic right shift and optionally saturates to the output width. A valid/ready handshake with full backpressure lets the quantiser/predictor loops stall it without losing samples.

---
 rtl/adpcm_main_mul_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/adpcm_main_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, optional round-half-up shift and saturation.
// Latency NUM_STAGE cycles at 1/cycle; the whole chain holds while out_valid is set and out_ready is low.
module adpcm_main_mul_pipe #(
    parameter int DIN0_WIDTH  = 14,
    parameter int DIN1_WIDTH  = 12,
    parameter int DOUT_WIDTH  = 26,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 2,
    parameter int SHIFT       = 0,
    parameter int SATURATE    = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  busy
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int RW = PW + 1;
    localparam int XW = ((RW > DOUT_WIDTH) ? RW : DOUT_WIDTH) + 1;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam logic [RW-1:0] RND   = (RW'(1) << SHIFT) >> 1;
    localparam logic [XW-1:0] S_MAX = {{(XW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [XW-1:0] S_MIN = {{(XW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic [XW-1:0] U_MAX = {{(XW-DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}};

    // One extra bit on the rounding add: the largest unsigned product plus the half-LSB can carry.
    function automatic logic [DOUT_WIDTH-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [RW-1:0] r;
        logic signed [XW-1:0] x;
        r = RW'(p) + $signed(RND);
        r = r >>> SHIFT;
        x = XW'(r);
        round_sat = x[DOUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (RES_SIGNED) begin
                if (x > $signed(S_MAX))
                    round_sat = S_MAX[DOUT_WIDTH-1:0];
                else if (x < $signed(S_MIN))
                    round_sat = S_MIN[DOUT_WIDTH-1:0];
            end else if (x[XW-1]) begin
                round_sat = '0;
            end else if (x > $signed(U_MAX)) begin
                round_sat = U_MAX[DOUT_WIDTH-1:0];
            end
        end
    endfunction

    logic [NUM_STAGE-1:0]  r_vld;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                  w_adv;
    logic signed [PW-1:0]  w_a;
    logic signed [PW-1:0]  w_b;

    assign w_adv     = out_ready | ~r_vld[NUM_STAGE-1];
    assign in_ready  = w_adv;
    assign out_valid = r_vld[NUM_STAGE-1];
    assign busy      = |r_vld;
    assign dout      = r_dout;
    assign w_a = (DIN0_SIGNED != 0) ? PW'($signed(din0)) : PW'($unsigned(din0));
    assign w_b = (DIN1_SIGNED != 0) ? PW'($signed(din1)) : PW'($unsigned(din1));

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_vld <= '0;
        end else if (w_adv) begin
            for (int i = NUM_STAGE - 1; i > 0; i--)
                r_vld[i] <= r_vld[i-1];
            r_vld[0] <= in_valid;
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_one
            logic signed [PW-1:0] w_prod;
            assign w_prod = w_a * w_b;

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n)
                    r_dout <= '0;
                else if (w_adv)
                    r_dout <= round_sat(w_prod);
            end
        end else if (NUM_STAGE == 2) begin : g_two
            logic signed [PW-1:0] r_a;
            logic signed [PW-1:0] r_b;
            logic signed [PW-1:0] w_prod;
            assign w_prod = r_a * r_b;

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_a    <= '0;
                    r_b    <= '0;
                    r_dout <= '0;
                end else if (w_adv) begin
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_dout <= round_sat(w_prod);
                end
            end
        end else begin : g_many
            logic signed [PW-1:0] r_a;
            logic signed [PW-1:0] r_b;
            logic signed [PW-1:0] w_prod;
            // r_p[0] is the stage-2 product; later entries only delay it to the final stage.
            logic signed [PW-1:0] r_p [NUM_STAGE-2];
            assign w_prod = r_a * r_b;

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_a    <= '0;
                    r_b    <= '0;
                    r_dout <= '0;
                    for (int i = 0; i < NUM_STAGE - 2; i++)
                        r_p[i] <= '0;
                end else if (w_adv) begin
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_p[0] <= w_prod;
                    for (int i = 1; i < NUM_STAGE - 2; i++)
                        r_p[i] <= r_p[i-1];
                    r_dout <= round_sat(r_p[NUM_STAGE-3]);
                end
            end
        end
    endgenerate
endmodule
